// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: redirect from execute, instruction-memory request/response,
// and the decode-side valid/ready stream. The fetch unit uses the master view.
interface ifu_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pred_pc;
    logic [INST_W-1:0] out_inst;
    logic [31:0]       fetch_cnt;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_pred_pc, out_inst, fetch_cnt
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_pred_pc, out_inst, fetch_cnt
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, static not-taken prediction,
// redirect from execute discards any wrong-path fetch.
module ifu #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input logic   clock,
    input logic   reset,
    ifu_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, OUT, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   redirect_tgt;
    logic [INST_W-1:0] inst, inst_nxt;
    logic [31:0]       cnt, cnt_nxt;
    logic              unused_redirect_lsb;

    assign redirect_tgt        = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
    assign pc_inc              = pc + PC_W'(4);

    // A redirect cycle suppresses both the request and the decode handoff.
    assign bus.imem_req_valid = (state == REQ) & ~bus.redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = (state == OUT) & ~bus.redirect_valid;
    assign bus.out_pc         = pc;
    assign bus.out_pred_pc    = pc_inc;
    assign bus.out_inst       = inst;
    assign bus.fetch_cnt      = cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
            inst  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        cnt_nxt   = cnt;
        case (state)
            REQ: begin
                if (bus.redirect_valid) pc_nxt = redirect_tgt;
                else if (bus.imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = bus.imem_resp_valid ? REQ : FLUSH;
                end else if (bus.imem_resp_valid) begin
                    inst_nxt  = bus.imem_resp_data;
                    state_nxt = OUT;
                end
            end
            FLUSH: begin
                // The in-flight response belongs to the abandoned path.
                if (bus.redirect_valid) pc_nxt = redirect_tgt;
                if (bus.imem_resp_valid) state_nxt = REQ;
            end
            OUT: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = REQ;
                end else if (bus.out_ready) begin
                    pc_nxt    = pc_inc;
                    cnt_nxt   = cnt + 32'd1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end
endmodule
